// File: rtl/canny_pkg.sv
// Shared definitions for the frame feeder and the accelerator's line controller.
package canny_pkg;

    localparam int unsigned PIX_W          = 8;
    localparam int unsigned IMG_WIDTH_DEF  = 512;
    localparam int unsigned IMG_HEIGHT_DEF = 512;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } feeder_state_e;

    // One stream beat: the pixel plus the sideband flags that travel with it.
    typedef struct packed {
        logic             user;
        logic             last;
        logic [PIX_W-1:0] data;
    } pixel_beat_t;

endpackage

// File: rtl/axis_skid_fifo2.sv
// Two-entry FIFO that absorbs the frame-buffer read latency ahead of the stream port.
module axis_skid_fifo2
    import canny_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  pixel_beat_t wr_beat,
    output logic [1:0]  count,
    output logic        out_valid,
    input  logic        out_ready,
    output pixel_beat_t out_beat
);

    pixel_beat_t slot [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic        push;
    logic        pop;

    // A write is accepted when there is room, including room freed by a same-cycle pop.
    always_comb begin
        pop  = out_valid && out_ready;
        push = wr_en && ((count != 2'd2) || pop);
    end

    // The head slot is never overwritten while it is presented, so the beat holds during stalls.
    assign out_valid = (count != 2'd0);
    assign out_beat  = slot[rd_ptr];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= wr_beat;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= 2'(count + 2'(push) - 2'(pop));
        end
    end

endmodule

// File: rtl/axis_frame_feeder.sv
// Streams a grayscale frame from the frame buffer to the edge-detection pipeline, line-paced by credits.
module axis_frame_feeder
    import canny_pkg::*;
#(
    parameter int unsigned IMG_WIDTH     = IMG_WIDTH_DEF,
    parameter int unsigned IMG_HEIGHT    = IMG_HEIGHT_DEF,
    parameter int unsigned PRELOAD_LINES = 4,
    parameter int unsigned ADDR_W        = 18,
    parameter int unsigned CREDIT_W      = 4
) (
    input  logic              axi_clk,
    input  logic              axi_rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              credit_err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    output logic              m_axis_tvalid,
    output logic [PIX_W-1:0]  m_axis_tdata,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    input  logic              line_req
);

    localparam int unsigned COL_W  = $clog2(IMG_WIDTH);
    localparam int unsigned LINE_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [COL_W-1:0]    COL_LAST    = COL_W'(IMG_WIDTH - 1);
    localparam logic [LINE_W-1:0]   LINE_LAST   = LINE_W'(IMG_HEIGHT - 1);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX  = '1;
    localparam logic [CREDIT_W-1:0] CREDIT_INIT = CREDIT_W'(PRELOAD_LINES);

    feeder_state_e       state;
    logic [COL_W-1:0]    col;
    logic [LINE_W-1:0]   line;
    logic [CREDIT_W-1:0] credits;
    logic                req_q;
    logic                inflight;
    logic                tag_last;
    logic                tag_user;

    logic [1:0]          fifo_count;
    logic [2:0]          occupancy;
    logic                pop;
    logic                line_ok;
    logic                rd_fire;
    logic                line_start;
    logic                req_edge;
    logic                last_pix;
    pixel_beat_t         wr_beat;
    pixel_beat_t         out_beat;

    // Read gating: a line needs a credit to start, and the FIFO plus the in-flight read may hold two beats.
    always_comb begin
        pop        = m_axis_tvalid && m_axis_tready;
        occupancy  = 3'(fifo_count) + 3'(inflight) - 3'(pop);
        line_ok    = (col != '0) || (credits != '0);
        rd_fire    = (state == ST_FETCH) && line_ok && (occupancy < 3'd2);
        line_start = rd_fire && (col == '0);
        req_edge   = line_req && !req_q && (state != ST_IDLE);
        last_pix   = (col == COL_LAST) && (line == LINE_LAST);
        wr_beat.user = tag_user;
        wr_beat.last = tag_last;
        wr_beat.data = mem_rd_data;
    end

    assign mem_rd_en = rd_fire;

    // Frame sequencing, address/position counters, line credits and status flags.
    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            state      <= ST_IDLE;
            col        <= '0;
            line       <= '0;
            credits    <= '0;
            mem_addr   <= '0;
            req_q      <= 1'b0;
            inflight   <= 1'b0;
            tag_last   <= 1'b0;
            tag_user   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            credit_err <= 1'b0;
        end else begin
            done     <= 1'b0;
            req_q    <= line_req;
            inflight <= rd_fire;

            if (rd_fire) begin
                tag_last <= (col == COL_LAST);
                tag_user <= (col == '0) && (line == '0);
            end

            // A request and a line start in the same cycle cancel out.
            if (req_edge && !line_start) begin
                if (credits == CREDIT_MAX) begin
                    credit_err <= 1'b1;
                end else begin
                    credits <= CREDIT_W'(credits + 1'b1);
                end
            end else if (line_start && !req_edge) begin
                credits <= CREDIT_W'(credits - 1'b1);
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_FETCH;
                        credits  <= CREDIT_INIT;
                        col      <= '0;
                        line     <= '0;
                        mem_addr <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (rd_fire) begin
                        if (last_pix) begin
                            state <= ST_DRAIN;
                        end else begin
                            mem_addr <= ADDR_W'(mem_addr + 1'b1);
                            if (col == COL_LAST) begin
                                col  <= '0;
                                line <= LINE_W'(line + 1'b1);
                            end else begin
                                col <= COL_W'(col + 1'b1);
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leave as the final beat is accepted, so done follows it directly.
                    if (occupancy == 3'd0) begin
                        state   <= ST_IDLE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        credits <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    axis_skid_fifo2 u_fifo (
        .clk       (axi_clk),
        .rst_n     (axi_rst_n),
        .wr_en     (inflight),
        .wr_beat   (wr_beat),
        .count     (fifo_count),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready),
        .out_beat  (out_beat)
    );

    assign m_axis_tdata = out_beat.data;
    assign m_axis_tlast = out_beat.last;
    assign m_axis_tuser = out_beat.user;

endmodule

// File: tb/tb_axis_frame_feeder.sv
// Bench for axis_frame_feeder: two instances (generous preload, and single-line preload with narrow credits).
module tb_axis_frame_feeder;

    localparam int W     = 4;
    localparam int H     = 3;
    localparam int TOTAL = W * H;
    localparam int AW    = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic       start    [2];
    logic       tready   [2];
    logic       line_req [2];
    logic       busy     [2];
    logic       done     [2];
    logic       credit_err [2];
    logic       rd_en    [2];
    logic       tvalid   [2];
    logic       tlast    [2];
    logic       tuser    [2];
    logic [7:0] rd_data  [2];
    logic [7:0] tdata    [2];
    logic [AW-1:0] addr  [2];
    logic [7:0] ram [2][16];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int acc     [2];
    int rds     [2];
    int dones   [2];
    int last_hs [2];
    logic       held_v [2];
    logic [9:0] held   [2];

    always #5 clk = ~clk;

    axis_frame_feeder #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .PRELOAD_LINES(3), .ADDR_W(AW), .CREDIT_W(4)
    ) dut_a (
        .axi_clk(clk), .axi_rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .credit_err(credit_err[0]), .mem_rd_en(rd_en[0]), .mem_addr(addr[0]),
        .mem_rd_data(rd_data[0]), .m_axis_tvalid(tvalid[0]), .m_axis_tdata(tdata[0]),
        .m_axis_tready(tready[0]), .m_axis_tlast(tlast[0]), .m_axis_tuser(tuser[0]),
        .line_req(line_req[0])
    );

    axis_frame_feeder #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .PRELOAD_LINES(1), .ADDR_W(AW), .CREDIT_W(2)
    ) dut_b (
        .axi_clk(clk), .axi_rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .credit_err(credit_err[1]), .mem_rd_en(rd_en[1]), .mem_addr(addr[1]),
        .mem_rd_data(rd_data[1]), .m_axis_tvalid(tvalid[1]), .m_axis_tdata(tdata[1]),
        .m_axis_tready(tready[1]), .m_axis_tlast(tlast[1]), .m_axis_tuser(tuser[1]),
        .line_req(line_req[1])
    );

    // Frame-buffer model: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en[0]) rd_data[0] <= ram[0][addr[0][3:0]];
        if (rd_en[1]) rd_data[1] <= ram[1][addr[1][3:0]];
    end

    // Reference stream: raster order, tlast at end of each line, tuser on the frame's first pixel.
    function automatic logic [9:0] exp_beat(input int k, input int i);
        return {(i == 0), ((i % W) == W - 1), ram[k][i]};
    endfunction

    function automatic logic [22:0] outs(input int k);
        return {busy[k], done[k], credit_err[k], rd_en[k], tvalid[k], tlast[k], tuser[k], tdata[k], addr[k]};
    endfunction

    // Stream monitor: ordering, data, stall stability, read pacing and done timing.
    initial begin : monitor
        logic [9:0] got;
        logic [9:0] want;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                for (int k = 0; k < 2; k++) begin
                    got = {tuser[k], tlast[k], tdata[k]};
                    if (held_v[k]) begin
                        vectors++;
                        if (tvalid[k] !== 1'b1 || got !== held[k]) begin
                            miscompares++;
                            $display("FAIL stall_hold dut%0d: got valid=%b beat=%h, want valid=1 beat=%h", k, tvalid[k], got, held[k]);
                        end
                    end
                    held_v[k] = tvalid[k] && !tready[k];
                    held[k]   = got;
                    if (tvalid[k] === 1'b1 && tready[k] === 1'b1) begin
                        vectors++;
                        if (acc[k] >= TOTAL) begin
                            miscompares++;
                            $display("FAIL extra_beat dut%0d: beat %0d got %h, want no beat", k, acc[k], got);
                        end else begin
                            want = exp_beat(k, acc[k]);
                            if (got !== want) begin
                                miscompares++;
                                $display("FAIL beat dut%0d: beat %0d got {user,last,data}=%h, want %h", k, acc[k], got, want);
                            end
                        end
                        acc[k]++;
                        last_hs[k] = cyc;
                    end
                    if (rd_en[k] === 1'b1) begin
                        vectors++;
                        if (addr[k] !== AW'(rds[k]) || (rds[k] - acc[k]) >= 2 || rds[k] >= TOTAL) begin
                            miscompares++;
                            $display("FAIL read_issue dut%0d: addr %0d with %0d reads / %0d accepted, want addr %0d and fewer than 2 pending", k, addr[k], rds[k], acc[k], rds[k]);
                        end
                        rds[k]++;
                    end
                    if (done[k] === 1'b1) begin
                        dones[k]++;
                        vectors++;
                        if (acc[k] != TOTAL || cyc != last_hs[k] + 1) begin
                            miscompares++;
                            $display("FAIL done_timing dut%0d: done at cycle %0d after %0d beats, want cycle %0d after %0d beats", k, cyc, acc[k], last_hs[k] + 1, TOTAL);
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic frame_reset(input int k);
        acc[k]     = 0;
        rds[k]     = 0;
        dones[k]   = 0;
        last_hs[k] = -10;
        held_v[k]  = 1'b0;
        for (int i = 0; i < 16; i++) ram[k][i] = 8'($urandom);
    endtask

    task automatic pulse_start(input int k);
        start[k] = 1'b1;
        step();
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget);
        int n = 0;
        while (dones[k] == 0 && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (outs(k) !== 23'd0) begin
                miscompares++;
                $display("FAIL reset_outputs dut%0d: got %h, want 0", k, outs(k));
            end
        end
        rst_n = 1'b1;
        run(2);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (outs(k) !== 23'd0) begin
                miscompares++;
                $display("FAIL idle_outputs dut%0d: got %h, want 0", k, outs(k));
            end
        end
    endtask

    task automatic test_throughput();
        logic [3:0] got;
        logic [3:0] want;
        frame_reset(0);
        tready[0] = 1'b1;
        pulse_start(0);
        for (int c = 0; c <= 15; c++) begin
            if (c > 0) step();
            got  = {rd_en[0], tvalid[0], done[0], busy[0]};
            want = {(c <= 11), (c >= 2 && c <= 13), (c == 14), (c <= 13)};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL throughput cycle %0d: {rd_en,tvalid,done,busy} got %b, want %b", c, got, want);
            end
        end
        vectors++;
        if (acc[0] != TOTAL || dones[0] != 1) begin
            miscompares++;
            $display("FAIL throughput_count: got %0d beats %0d done, want %0d beats 1 done", acc[0], dones[0], TOTAL);
        end
    endtask

    task automatic test_backpressure();
        int pat [4] = '{1, 0, 0, 1};
        int n = 0;
        frame_reset(0);
        tready[0] = 1'b1;
        pulse_start(0);
        while (dones[0] == 0 && n < 200) begin
            tready[0] = (pat[n % 4] != 0);
            step();
            n++;
        end
        tready[0] = 1'b1;
        vectors++;
        if (dones[0] != 1 || acc[0] != TOTAL || busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure: got %0d beats %0d done busy=%b, want %0d beats 1 done busy=0", acc[0], dones[0], busy[0], TOTAL);
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            int n = 0;
            frame_reset(0);
            pulse_start(0);
            while (dones[0] == 0 && n < 300) begin
                tready[0] = ($urandom_range(0, 2) != 0);
                start[0]  = (n == 7);
                step();
                n++;
            end
            start[0]  = 1'b0;
            tready[0] = 1'b1;
            vectors++;
            if (dones[0] != 1 || acc[0] != TOTAL || rds[0] != TOTAL) begin
                miscompares++;
                $display("FAIL back_to_back frame %0d: got %0d beats %0d reads %0d done, want %0d/%0d/1", f, acc[0], rds[0], dones[0], TOTAL, TOTAL);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int n = 0;
        frame_reset(0);
        tready[0] = 1'b1;
        pulse_start(0);
        while (acc[0] < 5 && n < 50) begin
            step();
            n++;
        end
        vectors++;
        if (acc[0] != 5 || tvalid[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_reach: got %0d beats valid=%b, want 5 beats valid=1", acc[0], tvalid[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (outs(0) !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_async: got %h, want 0", outs(0));
        end
        run(2);
        rst_n = 1'b1;
        step();
        vectors++;
        if (dones[0] != 0 || outs(0) !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_no_done: got %0d done outputs %h, want 0 done outputs 0", dones[0], outs(0));
        end
        frame_reset(0);
        pulse_start(0);
        wait_done(0, 60);
        vectors++;
        if (dones[0] != 1 || acc[0] != TOTAL) begin
            miscompares++;
            $display("FAIL reset_restart: got %0d beats %0d done, want %0d beats 1 done", acc[0], dones[0], TOTAL);
        end
    endtask

    task automatic test_credit_gating();
        frame_reset(1);
        tready[1] = 1'b1;
        pulse_start(1);
        run(20);
        vectors++;
        if (acc[1] != W || rds[1] != W || busy[1] !== 1'b1 || rd_en[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL gate_line0: got %0d beats %0d reads busy=%b rd_en=%b, want %0d/%0d busy=1 rd_en=0", acc[1], rds[1], busy[1], rd_en[1], W, W);
        end
        line_req[1] = 1'b1;
        run(10);
        line_req[1] = 1'b0;
        run(20);
        vectors++;
        if (acc[1] != 2 * W || rds[1] != 2 * W) begin
            miscompares++;
            $display("FAIL gate_held_req: got %0d beats %0d reads, want %0d/%0d", acc[1], rds[1], 2 * W, 2 * W);
        end
        line_req[1] = 1'b1;
        step();
        line_req[1] = 1'b0;
        wait_done(1, 40);
        vectors++;
        if (dones[1] != 1 || acc[1] != TOTAL || busy[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL gate_line2: got %0d beats %0d done busy=%b, want %0d beats 1 done busy=0", acc[1], dones[1], busy[1], TOTAL);
        end
    endtask

    task automatic test_simultaneous();
        frame_reset(1);
        tready[1] = 1'b1;
        pulse_start(1);
        vectors++;
        if (rd_en[1] !== 1'b1 || addr[1] !== '0) begin
            miscompares++;
            $display("FAIL simul_linestart: got rd_en=%b addr=%0d, want rd_en=1 addr=0", rd_en[1], addr[1]);
        end
        line_req[1] = 1'b1;
        step();
        line_req[1] = 1'b0;
        run(25);
        vectors++;
        if (acc[1] != 2 * W || rds[1] != 2 * W) begin
            miscompares++;
            $display("FAIL simul_credit: got %0d beats %0d reads, want %0d/%0d", acc[1], rds[1], 2 * W, 2 * W);
        end
        line_req[1] = 1'b1;
        step();
        line_req[1] = 1'b0;
        wait_done(1, 40);
        vectors++;
        if (dones[1] != 1 || acc[1] != TOTAL) begin
            miscompares++;
            $display("FAIL simul_finish: got %0d beats %0d done, want %0d beats 1 done", acc[1], dones[1], TOTAL);
        end
    endtask

    task automatic test_saturation();
        frame_reset(1);
        tready[1] = 1'b0;
        pulse_start(1);
        run(6);
        vectors++;
        if (rds[1] != 2 || acc[1] != 0 || credit_err[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_stall: got %0d reads %0d beats err=%b, want 2 reads 0 beats err=0", rds[1], acc[1], credit_err[1]);
        end
        repeat (5) begin
            line_req[1] = 1'b1;
            step();
            line_req[1] = 1'b0;
            step();
        end
        vectors++;
        if (credit_err[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_err: got credit_err=%b, want 1", credit_err[1]);
        end
        tready[1] = 1'b1;
        wait_done(1, 60);
        vectors++;
        if (dones[1] != 1 || acc[1] != TOTAL || credit_err[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_finish: got %0d beats %0d done err=%b, want %0d beats 1 done err=1", acc[1], dones[1], credit_err[1], TOTAL);
        end
    endtask

    task automatic test_err_clear();
        rst_n = 1'b0;
        step();
        vectors++;
        if (credit_err[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: got credit_err=%b, want 0", credit_err[1]);
        end
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            start[k]    = 1'b0;
            tready[k]   = 1'b0;
            line_req[k] = 1'b0;
            acc[k]      = 0;
            rds[k]      = 0;
            dones[k]    = 0;
            last_hs[k]  = -10;
            held_v[k]   = 1'b0;
            held[k]     = '0;
        end
        run(3);
        test_reset();
        test_throughput();
        test_backpressure();
        test_back_to_back();
        test_reset_midframe();
        test_credit_gating();
        test_simultaneous();
        test_saturation();
        test_err_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_frame_feeder.md
Name: axis_frame_feeder

Overview:
- AXI-Stream master that feeds an 8-bit grayscale frame from an on-chip frame buffer into the edge-detection pipeline's pixel slave port.
- Paces the frame line by line. It sends PRELOAD_LINES lines on start, then one further line per interrupt pulse raised by the pipeline's line controller.
- Sits between the frame-buffer RAM and the accelerator's pixel_in/pixel_in_valid/pixel_out_ready slave interface.

Parameters:
- IMG_WIDTH, 512, pixels per line (>=2)
- IMG_HEIGHT, 512, lines per frame (>=1)
- PRELOAD_LINES, 4, lines sent unconditionally after start (1..IMG_HEIGHT)
- ADDR_W, 18, frame-buffer address width (2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT)
- CREDIT_W, 4, width of line-credit counter

Ports:
- axi_clk  in  1  single clock
- axi_rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, begin frame (honoured only when idle)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last pixel beat is accepted
- credit_err  out  1  sticky; line request arrived with credit counter saturated
- mem_rd_en  out  1  frame-buffer read strobe
- mem_addr  out  ADDR_W  frame-buffer read address
- mem_rd_data  in  8  read data, valid exactly 1 cycle after mem_rd_en
- m_axis_tvalid  out  1  pixel valid (drives accelerator pixel_in_valid)
- m_axis_tdata  out  8  pixel (drives accelerator pixel_in)
- m_axis_tready  in  1  from accelerator pixel_out_ready
- m_axis_tlast  out  1  high on last pixel of each line
- m_axis_tuser  out  1  high on first pixel of frame
- line_req  in  1  accelerator interrupt; each rising edge grants one line credit

Behaviour:
- Reset (async, axi_rst_n=0): all outputs 0; state IDLE; credits, counters and FIFO cleared; credit_err cleared. Reset mid-frame aborts immediately. tvalid drops without handshake, and no done pulse is produced.
- FSM states:
  - IDLE -> FETCH on start: credits=PRELOAD_LINES, line=0, col=0, addr=0, busy=1.
  - FETCH -> DRAIN once the read for pixel (IMG_HEIGHT-1, IMG_WIDTH-1) is issued.
  - DRAIN -> IDLE when the output FIFO is empty and no read is in flight. done=1 for that cycle, busy=0.
- Line start: a line begins only when credits>0; credits decrement by 1 at the first read of each line. Within a line, reads continue regardless of credits.
- Read issue: mem_rd_en=1 in FETCH when line may proceed AND (fifo_count + inflight) < 2. mem_addr increments by 1 per read and never wraps mid-frame.
- Output path: 2-entry FIFO absorbs the 1-cycle RAM latency. It gives full throughput: 1 beat/cycle with tready held high once the pipeline is primed.
- First beat latency: 2 cycles after start when tready=1 (start -> read -> data into FIFO -> tvalid).
- AXI-Stream rules:
  - tdata/tlast/tuser stable while tvalid=1 and tready=0.
  - tvalid never deasserts without a handshake, except on reset.
  - tlast/tuser travel with their pixel through the FIFO.
- line_req: registered rising-edge detect; rising edges are counted in any state except IDLE, where they are ignored.
  - If an edge and a line start occur in the same cycle, credits are unchanged.
  - If credits equal 2^CREDIT_W-1 when an edge arrives, the credit is dropped and credit_err=1 (sticky until reset).
- Credits left at frame end are discarded on return to IDLE.
- start while busy is ignored.
- Arithmetic: col counts 0..IMG_WIDTH-1, line counts 0..IMG_HEIGHT-1, with counters sized by $clog2. tlast when col==IMG_WIDTH-1; tuser when line==0 and col==0.

Decomposition:
- Shared package canny_pkg: FSM state enum (ST_IDLE, ST_FETCH, ST_DRAIN), pixel width constant PIX_W=8, default IMG_WIDTH/IMG_HEIGHT used by the accelerator's line controller, so both ends agree.
- One sub-module: axis_skid_fifo2 (2-entry FIFO with count output, tvalid/tready on the read side).

Test Plan:
- Full throughput, IMG_WIDTH=4, IMG_HEIGHT=3, PRELOAD_LINES=3, tready=1, RAM[i]=i:
  - 12 beats on consecutive cycles, data 0..11.
  - tuser on beat 0; tlast on beats 3, 7, 11.
  - done one cycle after beat 11; busy low thereafter.
- Credit gating, PRELOAD_LINES=1, height 3:
  - Line 0 sent, then stall with mem_rd_en=0.
  - A line_req pulse sends line 1.
  - A second pulse sends line 2, then done.
  - A line_req held high for 10 cycles counts as one credit.
- Backpressure, tready toggling 1,0,0,1 repeatedly:
  - Every pixel delivered exactly once, in order.
  - tdata/tlast stable during stalls.
  - No read issued while fifo_count+inflight==2.
- Simultaneous events: line_req rising edge in the same cycle as line start with credits=1 -> credits stay 1, and the next line follows without a further request.
- Saturation, CREDIT_W=2:
  - Stall tready=0 and deliver 5 line_req edges -> credits cap at 3 and credit_err=1.
  - Remaining lines still complete on the capped credits.
- Reset mid-line at beat 5 -> all outputs 0 asynchronously; a new start resends from pixel 0 with tuser=1; no spurious done.
